// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I control path: opcode and immediate-format
// encodings plus the multicycle sequencer state type.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational instruction-to-control-field decoder, shared between
// the multicycle sequencer and any single-cycle variant.
module ctrl_decode
    import rv_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [1:0]  IMMs,
    output logic        ALUsrc,
    output logic [2:0]  ALUop,
    output logic        sub,
    output logic        MemtoReg,
    output logic        legal,
    output logic        is_load,
    output logic        is_store,
    output logic        is_branch
);

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign func3         = instr[14:12];
    assign func7         = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // Unsupported opcodes leave every field at zero so the datapath stays inert.
    always_comb begin
        IMMs      = IMM_I;
        ALUsrc    = 1'b0;
        ALUop     = 3'b000;
        sub       = 1'b0;
        MemtoReg  = 1'b0;
        legal     = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        case (opcode)
            OP_R: begin
                ALUop    = func3;
                sub      = |func7;
                MemtoReg = 1'b1;
                legal    = 1'b1;
            end
            OP_I: begin
                ALUsrc   = 1'b1;
                ALUop    = func3;
                MemtoReg = 1'b1;
                legal    = 1'b1;
            end
            OP_LOAD: begin
                ALUsrc  = 1'b1;
                legal   = 1'b1;
                is_load = 1'b1;
            end
            OP_STORE: begin
                IMMs     = IMM_S;
                ALUsrc   = 1'b1;
                legal    = 1'b1;
                is_store = 1'b1;
            end
            OP_BRANCH: begin
                IMMs      = IMM_B;
                sub       = 1'b1;
                legal     = 1'b1;
                is_branch = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I sequencer: walks FETCH/DECODE/EXEC/MEM/WB over req/ack
// memories, drives datapath strobes and counts retired instructions.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             Z,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             memRW,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             pc_we,
    output logic             PCsrc,
    output logic             regW,
    output logic             ALUsrc,
    output logic [2:0]       ALUop,
    output logic             sub,
    output logic [1:0]       IMMs,
    output logic             MemtoReg,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t state;
    state_t next_state;
    logic   boot;
    logic   active;
    logic   legal;
    logic   is_load;
    logic   is_store;
    logic   is_branch;

    ctrl_decode u_decode (
        .instr     (instr),
        .IMMs      (IMMs),
        .ALUsrc    (ALUsrc),
        .ALUop     (ALUop),
        .sub       (sub),
        .MemtoReg  (MemtoReg),
        .legal     (legal),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_branch (is_branch)
    );

    // boot marks the first cycle after reset, which stays quiet in FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            boot  <= 1'b1;
        end else begin
            state <= next_state;
            boot  <= 1'b0;
        end
    end

    assign active = !rst && !boot;

    always_ff @(posedge clk) begin
        if (rst)
            instret <= '0;
        else if (pc_we && !illegal)
            instret <= instret + CNT_W'(1);
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:  if (active && imem_ack) next_state = DECODE;
            DECODE: next_state = legal ? EXEC : FETCH;
            EXEC: begin
                if (is_branch)
                    next_state = FETCH;
                else if (is_load || is_store)
                    next_state = MEM;
                else
                    next_state = WB;
            end
            MEM:    if (dmem_ack) next_state = is_load ? WB : FETCH;
            WB:     next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // Strobes are forced low during reset so an open request drops at once.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        memRW    = 1'b0;
        ir_we    = 1'b0;
        mdr_we   = 1'b0;
        pc_we    = 1'b0;
        PCsrc    = 1'b0;
        regW     = 1'b0;
        illegal  = 1'b0;
        if (active) begin
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                DECODE: begin
                    illegal = !legal;
                    pc_we   = !legal;
                end
                EXEC: begin
                    pc_we = is_branch;
                    PCsrc = is_branch && Z;
                end
                MEM: begin
                    dmem_req = 1'b1;
                    memRW    = is_store;
                    mdr_we   = dmem_ack && is_load;
                    pc_we    = dmem_ack && is_store;
                end
                WB: begin
                    regW  = 1'b1;
                    pc_we = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a cycle-by-cycle vector table for the
// instruction sequences plus hand-written reset-in-every-state sequences.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        Z;
    logic        imem_ack;
    logic        dmem_ack;
    logic        imem_req, dmem_req, memRW, ir_we, mdr_we, pc_we, PCsrc, regW;
    logic        ALUsrc, sub, MemtoReg, illegal;
    logic [2:0]  ALUop;
    logic [1:0]  IMMs;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .Z        (Z),
        .imem_ack (imem_ack),
        .dmem_ack (dmem_ack),
        .imem_req (imem_req),
        .dmem_req (dmem_req),
        .memRW    (memRW),
        .ir_we    (ir_we),
        .mdr_we   (mdr_we),
        .pc_we    (pc_we),
        .PCsrc    (PCsrc),
        .regW     (regW),
        .ALUsrc   (ALUsrc),
        .ALUop    (ALUop),
        .sub      (sub),
        .IMMs     (IMMs),
        .MemtoReg (MemtoReg),
        .illegal  (illegal),
        .instret  (instret)
    );

    always #5 clk = ~clk;

    // Strobe bits: imem_req dmem_req memRW ir_we mdr_we pc_we PCsrc regW illegal
    logic [8:0] strobes;
    logic [7:0] dec;
    assign strobes = {imem_req, dmem_req, memRW, ir_we, mdr_we, pc_we, PCsrc, regW, illegal};
    assign dec     = {ALUsrc, ALUop, sub, IMMs, MemtoReg};

    localparam logic [8:0] S_NONE  = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] S_FREQ  = 9'b1_0_0_0_0_0_0_0_0;
    localparam logic [8:0] S_FACK  = 9'b1_0_0_1_0_0_0_0_0;
    localparam logic [8:0] S_WB    = 9'b0_0_0_0_0_1_0_1_0;
    localparam logic [8:0] S_LDMEM = 9'b0_1_0_0_0_0_0_0_0;
    localparam logic [8:0] S_LDACK = 9'b0_1_0_0_1_0_0_0_0;
    localparam logic [8:0] S_STMEM = 9'b0_1_1_0_0_0_0_0_0;
    localparam logic [8:0] S_STACK = 9'b0_1_1_0_0_1_0_0_0;
    localparam logic [8:0] S_BR_T  = 9'b0_0_0_0_0_1_1_0_0;
    localparam logic [8:0] S_BR_N  = 9'b0_0_0_0_0_1_0_0_0;
    localparam logic [8:0] S_ILL   = 9'b0_0_0_0_0_1_0_0_1;

    localparam logic [31:0] I_ADD  = 32'h0020_8033;
    localparam logic [31:0] I_SUB  = 32'h4020_8033;
    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_ORI  = 32'h00F0_E193;
    localparam logic [31:0] I_LW   = 32'h0000_A103;
    localparam logic [31:0] I_SW   = 32'h0020_A223;
    localparam logic [31:0] I_BEQ  = 32'h0000_0063;
    localparam logic [31:0] I_BAD  = 32'h0000_007F;

    // Decoded fields: ALUsrc ALUop[2:0] sub IMMs[1:0] MemtoReg
    localparam logic [7:0] D_ADD  = 8'b0_000_0_00_1;
    localparam logic [7:0] D_SUB  = 8'b0_000_1_00_1;
    localparam logic [7:0] D_ADDI = 8'b1_000_0_00_1;
    localparam logic [7:0] D_ORI  = 8'b1_110_0_00_1;
    localparam logic [7:0] D_LW   = 8'b1_000_0_00_0;
    localparam logic [7:0] D_SW   = 8'b1_000_0_01_0;
    localparam logic [7:0] D_BEQ  = 8'b0_000_1_10_0;
    localparam logic [7:0] D_BAD  = 8'b0_000_0_00_0;

    typedef struct {
        logic [31:0] instr;
        logic        z;
        logic        iack;
        logic        dack;
        logic [8:0]  exp_strobes;
        logic [7:0]  exp_dec;
        logic [31:0] exp_instret;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] i, logic z, logic ia, logic da,
                                logic [8:0] s, logic [7:0] d, logic [31:0] n);
        vec_t v;
        v.instr = i; v.z = z; v.iack = ia; v.dack = da;
        v.exp_strobes = s; v.exp_dec = d; v.exp_instret = n;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        instr    = v.instr;
        Z        = v.z;
        imem_ack = v.iack;
        dmem_ack = v.dack;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; instr = '0; Z = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;

        // One row per clock cycle, starting with the quiet cycle after reset.
        vecs.push_back(mk(I_ADD,  0, 0, 0, S_NONE,  D_ADD,  0));
        vecs.push_back(mk(I_ADD,  0, 1, 0, S_FACK,  D_ADD,  0));
        vecs.push_back(mk(I_ADD,  0, 0, 0, S_NONE,  D_ADD,  0));
        vecs.push_back(mk(I_ADD,  0, 0, 0, S_NONE,  D_ADD,  0));
        vecs.push_back(mk(I_ADD,  0, 0, 0, S_WB,    D_ADD,  0));
        vecs.push_back(mk(I_SUB,  0, 0, 1, S_FREQ,  D_SUB,  1));
        vecs.push_back(mk(I_SUB,  0, 1, 0, S_FACK,  D_SUB,  1));
        vecs.push_back(mk(I_SUB,  0, 0, 0, S_NONE,  D_SUB,  1));
        vecs.push_back(mk(I_SUB,  0, 0, 0, S_NONE,  D_SUB,  1));
        vecs.push_back(mk(I_SUB,  0, 0, 0, S_WB,    D_SUB,  1));
        vecs.push_back(mk(I_ADDI, 0, 1, 0, S_FACK,  D_ADDI, 2));
        vecs.push_back(mk(I_ADDI, 0, 0, 0, S_NONE,  D_ADDI, 2));
        vecs.push_back(mk(I_ADDI, 0, 0, 0, S_NONE,  D_ADDI, 2));
        vecs.push_back(mk(I_ADDI, 0, 0, 0, S_WB,    D_ADDI, 2));
        vecs.push_back(mk(I_LW,   0, 1, 0, S_FACK,  D_LW,   3));
        vecs.push_back(mk(I_LW,   0, 0, 0, S_NONE,  D_LW,   3));
        vecs.push_back(mk(I_LW,   0, 0, 0, S_NONE,  D_LW,   3));
        vecs.push_back(mk(I_LW,   0, 0, 0, S_LDMEM, D_LW,   3));
        vecs.push_back(mk(I_LW,   0, 1, 0, S_LDMEM, D_LW,   3));
        vecs.push_back(mk(I_LW,   0, 0, 0, S_LDMEM, D_LW,   3));
        vecs.push_back(mk(I_LW,   0, 0, 1, S_LDACK, D_LW,   3));
        vecs.push_back(mk(I_LW,   0, 0, 0, S_WB,    D_LW,   3));
        vecs.push_back(mk(I_SW,   0, 1, 0, S_FACK,  D_SW,   4));
        vecs.push_back(mk(I_SW,   0, 0, 0, S_NONE,  D_SW,   4));
        vecs.push_back(mk(I_SW,   0, 0, 0, S_NONE,  D_SW,   4));
        vecs.push_back(mk(I_SW,   0, 0, 0, S_STMEM, D_SW,   4));
        vecs.push_back(mk(I_SW,   0, 0, 1, S_STACK, D_SW,   4));
        vecs.push_back(mk(I_BEQ,  1, 1, 0, S_FACK,  D_BEQ,  5));
        vecs.push_back(mk(I_BEQ,  1, 0, 0, S_NONE,  D_BEQ,  5));
        vecs.push_back(mk(I_BEQ,  1, 0, 0, S_BR_T,  D_BEQ,  5));
        vecs.push_back(mk(I_BEQ,  0, 1, 0, S_FACK,  D_BEQ,  6));
        vecs.push_back(mk(I_BEQ,  0, 0, 0, S_NONE,  D_BEQ,  6));
        vecs.push_back(mk(I_BEQ,  0, 0, 0, S_BR_N,  D_BEQ,  6));
        vecs.push_back(mk(I_BAD,  1, 1, 0, S_FACK,  D_BAD,  7));
        vecs.push_back(mk(I_BAD,  1, 0, 0, S_ILL,   D_BAD,  7));
        vecs.push_back(mk(I_ORI,  0, 1, 0, S_FACK,  D_ORI,  7));
        vecs.push_back(mk(I_ORI,  0, 0, 0, S_NONE,  D_ORI,  7));
        vecs.push_back(mk(I_ORI,  0, 0, 0, S_NONE,  D_ORI,  7));
        vecs.push_back(mk(I_ORI,  0, 0, 0, S_WB,    D_ORI,  7));
        vecs.push_back(mk(I_ORI,  0, 0, 0, S_FREQ,  D_ORI,  8));

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("row%0d strobes", i), 32'(strobes), 32'(vecs[i].exp_strobes));
            checkOutput($sformatf("row%0d decode", i),  32'(dec),     32'(vecs[i].exp_dec));
            checkOutput($sformatf("row%0d instret", i), instret,      vecs[i].exp_instret);
            tick();
        end

        // Reset asserted for one cycle while parked in each state in turn.
        for (int k = 0; k < 5; k++) begin
            rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; instr = I_LW;
            tick();
            rst = 1'b0;
            tick();
            imem_ack = (k >= 1);
            dmem_ack = (k == 4);
            for (int s = 0; s < k; s++) tick();
            rst = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("rst k%0d during", k), 32'(strobes), 32'(S_NONE));
            tick();
            rst = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("rst k%0d after strobes", k), 32'(strobes), 32'(S_NONE));
            checkOutput($sformatf("rst k%0d after instret", k), instret, 32'd0);
            tick();
            @(negedge clk);
            checkOutput($sformatf("rst k%0d fetch", k), 32'(strobes), 32'(S_FACK));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- FSM controller that sequences the RV32I datapath over several cycles: FETCH, DECODE, EXEC, MEM, WB.
- Replaces single-cycle decode when instruction and data memories are shared or slow and answer through req/ack handshakes.
- Drives the same datapath control fields (IMMs, ALUsrc, ALUop, sub, MemtoReg, PCsrc, memRW, regW), plus register-enable strobes and memory requests.
- Keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- instr  input  32  current IR contents; fields opcode[6:0], func3[14:12], func7[31:25]
- Z  input  1  ALU zero flag
- imem_ack  input  1  instruction memory has data valid this cycle
- dmem_ack  input  1  data memory read data valid, or write done, this cycle
- imem_req  output  1  instruction fetch request
- dmem_req  output  1  data memory request
- memRW  output  1  1 = write, 0 = read; meaningful only with dmem_req
- ir_we  output  1  load IR from instruction memory
- mdr_we  output  1  load memory data register
- pc_we  output  1  update PC
- PCsrc  output  1  0 = PC+4, 1 = branch target
- regW  output  1  register file write enable
- ALUsrc  output  1  0 = rs2, 1 = immediate
- ALUop  output  3  ALU function
- sub  output  1  ALU subtract
- IMMs  output  2  immediate format: 00 = I, 01 = S, 10 = B
- MemtoReg  output  1  1 = ALU result, 0 = MDR
- illegal  output  1  one-cycle pulse on an unsupported opcode
- instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset (rst high at a clock edge):
  - Next state is FETCH, instret = 0.
  - All strobes are 0 the cycle after reset: imem_req, dmem_req, ir_we, mdr_we, pc_we, regW, illegal.
  - Reset mid-handshake drops the request immediately; no completion is owed.
- Decoded fields are combinational from instr and valid from DECODE onward:
  - R (0110011): IMMs=00, ALUsrc=0, ALUop=func3, sub=(func7!=0), MemtoReg=1.
  - I-ALU (0010011): IMMs=00, ALUsrc=1, ALUop=func3, sub=0, MemtoReg=1.
  - LOAD (0000011): IMMs=00, ALUsrc=1, ALUop=000, sub=0, MemtoReg=0.
  - STORE (0100011): IMMs=01, ALUsrc=1, ALUop=000, sub=0.
  - BRANCH (1100011): IMMs=10, ALUsrc=0, ALUop=000, sub=1.
  - Any other opcode: all fields 0.
- FETCH:
  - imem_req=1, held until imem_ack.
  - In the ack cycle: ir_we=1, next state DECODE.
  - No timeout.
- DECODE (1 cycle):
  - Legal opcode: go to EXEC.
  - Illegal opcode: illegal=1, pc_we=1, PCsrc=0, go to FETCH; instret does not increment.
- EXEC (1 cycle):
  - R / I-ALU: go to WB.
  - LOAD / STORE: go to MEM.
  - BRANCH: pc_we=1, PCsrc=Z, go to FETCH.
- MEM:
  - dmem_req=1; memRW=1 for STORE, 0 for LOAD. Held stable until dmem_ack.
  - On ack, LOAD: mdr_we=1, go to WB.
  - On ack, STORE: pc_we=1, PCsrc=0, go to FETCH.
- WB (1 cycle): regW=1, pc_we=1, PCsrc=0, go to FETCH.
- Retirement:
  - instret increments by 1 on every pc_we cycle except the illegal path.
  - Wraps modulo 2^CNT_W.
- Handshake rules:
  - An ack arriving while the matching req is low is ignored.
  - An ack in the same cycle the req is first raised is accepted (zero-wait memory).
  - imem_req and dmem_req are never high together.
- Cycle counts with zero-wait memory:
  - R/I: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- PCsrc is 0 whenever pc_we is 0.
- regW is high only in WB.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH;
  - IMMs encodings IMM_I, IMM_S, IMM_B;
  - the state enum FETCH, DECODE, EXEC, MEM, WB.
- One natural sub-module, ctrl_decode: the purely combinational instr-to-fields decoder, reusable by a future single-cycle variant.
- The FSM, strobes and counter stay in multicycle_ctrl.

Test Plan:
- Reset in every state (rst held 1 cycle) -> next cycle is FETCH, all strobes 0, instret=0.
- ADD (instr=0x00208033), zero-wait acks -> ir_we at cycle 1, regW and pc_we at cycle 4, MemtoReg=1, ALUop=000, sub=0, instret=1.
- SUB (func7=0100000) then ADDI x1,x0,5 -> sub=1 then sub=0; ADDI gives ALUsrc=1, IMMs=00; instret=2.
- LW with dmem_ack delayed 3 cycles -> dmem_req=1, memRW=0 held 3 cycles; mdr_we on the ack cycle; next cycle regW=1, MemtoReg=0.
- SW, then BEQ with Z=1, then BEQ with Z=0:
  - SW -> memRW=1 until ack, pc_we on ack.
  - BEQ with Z=1 -> pc_we=1, PCsrc=1 in EXEC.
  - BEQ with Z=0 -> pc_we=1, PCsrc=0.
- Opcode 0x7F -> illegal pulse for one cycle in DECODE, pc_we=1, instret unchanged. Separately, a spurious dmem_ack during FETCH is ignored.
